// File: rtl/decoder_scan_pkg.sv
// Purpose: shared types and constants for the decoder channel scanner.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: scan FSM state enum, channel count, select index width.
package decoder_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    // BLANK is only ever entered when DECODER_SCAN_BLANK_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_next_idx.sv
// Purpose: rotating-priority picker, first enabled channel after sel (circular).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: sel (current index), mask (channel enables) -> next (chosen index),
//        wrap (next <= sel, i.e. the search passed channel 3).
module scan_next_idx
    import decoder_scan_pkg::*;
(
    input  logic [IDX_W-1:0]  sel,
    input  logic [NUM_CH-1:0] mask,
    output logic [IDX_W-1:0]  next,
    output logic              wrap
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Offsets 1..NUM_CH: the last offset lands back on sel itself, so a
    // single-channel mask reselects the same channel and reports a wrap.
    always_comb begin
        next  = sel;
        cand  = sel;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = sel + IDX_W'(i);
            if (!found && mask[cand]) begin
                next  = cand;
                found = 1'b1;
            end
        end
        wrap = (next <= sel);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Purpose: round-robin select sequencer for the 2-to-4 decoder (auto dwell or manual step).
// Latency: 1 cycle from sampled en/step/dwell end to registered sel/sel_valid/wrap.
// Backpressure: none; downstream decodes sel only while sel_valid is high.
// Ports: clk, rst_n (async active-low), en, mode (0 auto / 1 manual), step, mask[3:0]
//        -> sel[1:0], sel_valid, wrap. Optional blanking: DECODER_SCAN_BLANK_EN.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              step,
    input  logic [NUM_CH-1:0] mask,
    output logic [IDX_W-1:0]  sel,
    output logic              sel_valid,
    output logic              wrap
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(PRESCALE - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic             valid_nxt, wrap_nxt;
    logic             mode_q;

    logic [IDX_W-1:0] pick_in, pick_idx;
    logic             pick_wrap;
    logic             go, mode_chg, adv;

`ifdef DECODER_SCAN_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
    logic [7:0] bcnt, bcnt_nxt;
`endif

    // From IDLE, searching after the last channel yields the lowest set bit.
    assign pick_in  = (state == IDLE) ? IDX_W'(NUM_CH - 1) : sel;
    assign go       = en && (mask != '0);
    assign mode_chg = (mode != mode_q);
    // A mode change restarts the dwell, so it can never complete on that edge.
    assign adv      = mode ? step : (!mode_chg && (cnt == DWELL_LAST));

    scan_next_idx u_next_idx (
        .sel  (pick_in),
        .mask (mask),
        .next (pick_idx),
        .wrap (pick_wrap)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        valid_nxt = sel_valid;
        wrap_nxt  = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
        bcnt_nxt  = bcnt;
`endif
        if (!go) begin
            // Disable (or empty mask) beats any pending advance.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ACTIVE;
                    sel_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
                ACTIVE: begin
                    if (adv) begin
                        sel_nxt  = pick_idx;
                        wrap_nxt = pick_wrap;
                        cnt_nxt  = '0;
`ifdef DECODER_SCAN_BLANK_EN
                        state_nxt = BLANK;
                        valid_nxt = 1'b0;
                        bcnt_nxt  = '0;
`endif
                    end else if (mode || mode_chg) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                BLANK: begin
                    // Steps are ignored here; the dwell restarts on return.
                    cnt_nxt = '0;
                    if (bcnt == BLANK_LAST) begin
                        state_nxt = ACTIVE;
                        valid_nxt = 1'b1;
                    end else begin
                        bcnt_nxt = bcnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            sel_valid <= valid_nxt;
            wrap      <= wrap_nxt;
            mode_q    <= mode;
        end
    end

`ifdef DECODER_SCAN_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else begin
            bcnt <= bcnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Purpose: directed self-checking bench for decoder_scan_ctrl (PRESCALE=4, BLANK_CYC=2).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a; expectations follow DECODER_SCAN_BLANK_EN when defined.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, step;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       sel_valid, wrap;

    int compared   = 0;
    int mismatched = 0;

`ifdef DECODER_SCAN_BLANK_EN
    localparam logic ADV_VLD = 1'b0;
`else
    localparam logic ADV_VLD = 1'b1;
`endif

    decoder_scan_ctrl #(
        .PRESCALE  (4),
        .BLANK_CYC (2),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .mask      (mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_sel, input logic e_vld,
                           input logic e_wrap);
        chk({tag, ".sel"},       32'(sel),       32'(e_sel));
        chk({tag, ".sel_valid"}, 32'(sel_valid), 32'(e_vld));
        chk({tag, ".wrap"},      32'(wrap),      32'(e_wrap));
    endtask

    // One full auto dwell on cur, then the advance to nxt (plus blanking).
    task automatic auto_dwell(input logic [1:0] cur, input logic [1:0] nxt, input logic e_wrap);
        repeat (3) begin
            tick();
            chk_out("dwell_hold", cur, 1'b1, 1'b0);
        end
        tick();
        chk_out("dwell_adv", nxt, ADV_VLD, e_wrap);
`ifdef DECODER_SCAN_BLANK_EN
        tick();
        chk_out("blank_2nd", nxt, 1'b0, 1'b0);
        tick();
        chk_out("blank_exit", nxt, 1'b1, 1'b0);
`endif
    endtask

    // Single manual step pulse, then enough quiet cycles to settle.
    task automatic adv_manual(input logic [1:0] e_sel, input logic e_wrap);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_out("man_adv", e_sel, ADV_VLD, e_wrap);
`ifdef DECODER_SCAN_BLANK_EN
        tick();
        chk_out("man_blank", e_sel, 1'b0, 1'b0);
`endif
        tick();
        chk_out("man_settle", e_sel, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        step  = 1'b0;
        mask  = 4'b1111;
        #3;
        chk_out("reset", 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("idle_en0", 2'd0, 1'b0, 1'b0);

        // Auto scan, all channels: 0,1,2,3,0, wrap only on 3->0.
        en = 1'b1;
        tick();
        chk_out("en_rise", 2'd0, 1'b1, 1'b0);
        auto_dwell(2'd0, 2'd1, 1'b0);
        auto_dwell(2'd1, 2'd2, 1'b0);
        auto_dwell(2'd2, 2'd3, 1'b0);
        auto_dwell(2'd3, 2'd0, 1'b1);

        // Mask 1010 while on channel 0: dwell completes, then 1,3,1,3,1.
        mask = 4'b1010;
        auto_dwell(2'd0, 2'd1, 1'b0);
        auto_dwell(2'd1, 2'd3, 1'b0);
        auto_dwell(2'd3, 2'd1, 1'b1);
        auto_dwell(2'd1, 2'd3, 1'b0);
        auto_dwell(2'd3, 2'd1, 1'b1);

        // Disable, then manual mode from the lowest channel.
        en = 1'b0;
        tick();
        chk_out("en_drop", 2'd1, 1'b0, 1'b0);
        mode = 1'b1;
        mask = 4'b1111;
        en   = 1'b1;
        tick();
        chk_out("man_start", 2'd0, 1'b1, 1'b0);
        adv_manual(2'd1, 1'b0);
`ifndef DECODER_SCAN_BLANK_EN
        // Back-to-back step cycles each advance once.
        step = 1'b1;
        tick();
        chk_out("step_b2b_1", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("step_b2b_2", 2'd3, 1'b1, 1'b0);
        tick();
        chk_out("step_b2b_3", 2'd0, 1'b1, 1'b1);
        step = 1'b0;
        tick();
        chk_out("step_b2b_q", 2'd0, 1'b1, 1'b0);
        adv_manual(2'd1, 1'b0);
`endif
        adv_manual(2'd2, 1'b0);
        // No self-advance in manual mode, even well past PRESCALE cycles.
        repeat (6) begin
            tick();
            chk_out("man_hold", 2'd2, 1'b1, 1'b0);
        end

        // en=0 together with step: disable wins, sel holds at 2.
        en   = 1'b0;
        step = 1'b1;
        tick();
        chk_out("en_vs_step", 2'd2, 1'b0, 1'b0);
        step = 1'b0;
        mode = 1'b0;
        mask = 4'b1110;
        en   = 1'b1;
        tick();
        chk_out("reenable_low", 2'd1, 1'b1, 1'b0);

        // Empty mask drops to IDLE and stays there while en is high.
        mask = 4'b0000;
        tick();
        chk_out("mask0_drop", 2'd1, 1'b0, 1'b0);
        tick();
        chk_out("mask0_idle", 2'd1, 1'b0, 1'b0);

        // Mode change restarts the dwell counter.
        mask = 4'b1111;
        tick();
        chk_out("mc_start", 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("mc_cnt2", 2'd0, 1'b1, 1'b0);
        mode = 1'b1;
        tick();
        chk_out("mc_to_man", 2'd0, 1'b1, 1'b0);
        mode = 1'b0;
        tick();
        chk_out("mc_to_auto", 2'd0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk_out("mc_restart", 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_out("mc_adv", 2'd1, ADV_VLD, 1'b0);

        // Asynchronous reset mid-operation (mid-blank when blanking is built in).
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 2'd0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
